truth_table_stimulus_seq: RTL and testbench

Drive side of the logic-tester truth-table path. Steps through a truth table held in an external row RAM and applies each row's stimulus vector and drive enables to the DUT pins. After a programmable settle time it strobes the per-channel truth-table detectors and samples their pass/fail outputs. Results are aggregated into a pass flag, the first failing row and mask, and a failing-row count for the Ethernet reporting logic.

---
 rtl/truth_table_stimulus_seq_if.sv | 42 ++++
 rtl/truth_table_stimulus_seq.sv | 179 +++++++++++++++++
 tb/tb_truth_table_stimulus_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_stimulus_seq_if.sv
// Bundle of run-control, row-RAM, pin and result signals of the truth-table drive sequencer.
// The master modport is the sequencer; slave is the RAM/detector/reporting side.
interface truth_table_stimulus_seq_if #(
   parameter int P_CH_NUM   = 16,
   parameter int P_ROW_AW   = 6,
   parameter int P_SETTLE_W = 16,
   parameter int P_CNT_W    = 8
) ();
   logic                    i_start;
   logic [P_ROW_AW:0]       i_row_count;
   logic [P_SETTLE_W-1:0]   i_settle_cycles;
   logic                    i_stop_on_fail;
   logic [P_ROW_AW-1:0]     o_row_addr;
   logic                    o_row_rd;
   logic [P_CH_NUM-1:0]     i_row_stim;
   logic [P_CH_NUM-1:0]     i_row_chk;
   logic [P_CH_NUM-1:0]     o_stim_data;
   logic [P_CH_NUM-1:0]     o_stim_oe;
   logic [P_CH_NUM-1:0]     o_channel_vld;
   logic                    o_check_strobe;
   logic [P_CH_NUM-1:0]     i_detect_vld;
   logic                    o_busy;
   logic                    o_done;
   logic                    o_pass;
   logic [P_ROW_AW-1:0]     o_fail_row;
   logic [P_CH_NUM-1:0]     o_fail_mask;
   logic [P_CNT_W-1:0]      o_fail_cnt;

   modport master (
      input  i_start, i_row_count, i_settle_cycles, i_stop_on_fail,
      input  i_row_stim, i_row_chk, i_detect_vld,
      output o_row_addr, o_row_rd, o_stim_data, o_stim_oe, o_channel_vld,
      output o_check_strobe, o_busy, o_done, o_pass, o_fail_row, o_fail_mask, o_fail_cnt
   );

   modport slave (
      output i_start, i_row_count, i_settle_cycles, i_stop_on_fail,
      output i_row_stim, i_row_chk, i_detect_vld,
      input  o_row_addr, o_row_rd, o_stim_data, o_stim_oe, o_channel_vld,
      input  o_check_strobe, o_busy, o_done, o_pass, o_fail_row, o_fail_mask, o_fail_cnt
   );
endinterface

// File: rtl/truth_table_stimulus_seq.sv
// Truth-table drive sequencer: reads each row, applies stimulus and drive enables, waits
// the settle time, strobes the detectors and aggregates pass/fail results for reporting.
module truth_table_stimulus_seq #(
   parameter int P_CH_NUM   = 16,
   parameter int P_ROW_AW   = 6,
   parameter int P_SETTLE_W = 16,
   parameter int P_CNT_W    = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   truth_table_stimulus_seq_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_LATCH  = 3'd2,
      S_SETTLE = 3'd3,
      S_CHECK  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [P_ROW_AW:0]     LP_ROW_MAX    = {1'b1, {P_ROW_AW{1'b0}}};
   localparam logic [P_ROW_AW:0]     LP_COUNT_ONE  = {{P_ROW_AW{1'b0}}, 1'b1};
   localparam logic [P_ROW_AW-1:0]   LP_IDX_ONE    = {{(P_ROW_AW-1){1'b0}}, 1'b1};
   localparam logic [P_SETTLE_W-1:0] LP_SETTLE_ONE = {{(P_SETTLE_W-1){1'b0}}, 1'b1};
   localparam logic [P_CNT_W-1:0]    LP_CNT_ONE    = {{(P_CNT_W-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic [P_ROW_AW:0]       row_count_q;
   logic [P_SETTLE_W-1:0]   settle_q;
   logic [P_SETTLE_W-1:0]   settle_cnt_q;
   logic                    stop_q;
   logic [P_ROW_AW-1:0]     row_idx_q;
   logic [P_ROW_AW-1:0]     row_addr_q;
   logic                    row_rd_q;
   logic [P_CH_NUM-1:0]     stim_data_q;
   logic [P_CH_NUM-1:0]     stim_oe_q;
   logic [P_CH_NUM-1:0]     channel_vld_q;
   logic                    check_strobe_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    pass_q;
   logic [P_ROW_AW-1:0]     fail_row_q;
   logic [P_CH_NUM-1:0]     fail_mask_q;
   logic [P_CNT_W-1:0]      fail_cnt_q;

   logic [P_ROW_AW:0]       row_count_d;
   logic [P_ROW_AW-1:0]     row_idx_d;
   logic [P_CNT_W-1:0]      fail_cnt_d;
   logic                    row_fail_s;
   logic                    last_row_s;

   // Counts beyond the table depth are clamped so the row index can never wrap.
   assign row_count_d = (bus.i_row_count > LP_ROW_MAX) ? LP_ROW_MAX : bus.i_row_count;
   assign row_idx_d   = row_idx_q + LP_IDX_ONE;
   assign fail_cnt_d  = (&fail_cnt_q) ? fail_cnt_q : (fail_cnt_q + LP_CNT_ONE);
   assign row_fail_s  = ~(&bus.i_detect_vld);
   assign last_row_s  = ({1'b0, row_idx_q} == (row_count_q - LP_COUNT_ONE));

   // Sequencer FSM; every output is a register updated on the transition into its state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q        <= S_IDLE;
         row_count_q    <= '0;
         settle_q       <= '0;
         settle_cnt_q   <= '0;
         stop_q         <= 1'b0;
         row_idx_q      <= '0;
         row_addr_q     <= '0;
         row_rd_q       <= 1'b0;
         stim_data_q    <= '0;
         stim_oe_q      <= '0;
         channel_vld_q  <= '0;
         check_strobe_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b1;
         fail_row_q     <= '0;
         fail_mask_q    <= '0;
         fail_cnt_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_start) begin
                  row_count_q <= row_count_d;
                  settle_q    <= bus.i_settle_cycles;
                  stop_q      <= bus.i_stop_on_fail;
                  row_idx_q   <= '0;
                  pass_q      <= 1'b1;
                  fail_row_q  <= '0;
                  fail_mask_q <= '0;
                  fail_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  if (row_count_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_READ;
                     row_rd_q   <= 1'b1;
                     row_addr_q <= '0;
                  end
               end
            end
            S_READ: begin
               row_rd_q <= 1'b0;
               state_q  <= S_LATCH;
            end
            S_LATCH: begin
               stim_data_q   <= bus.i_row_stim;
               stim_oe_q     <= ~bus.i_row_chk;
               channel_vld_q <= bus.i_row_chk;
               if (settle_q != '0) begin
                  settle_cnt_q <= settle_q;
                  state_q      <= S_SETTLE;
               end else begin
                  check_strobe_q <= 1'b1;
                  state_q        <= S_CHECK;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == LP_SETTLE_ONE) begin
                  check_strobe_q <= 1'b1;
                  state_q        <= S_CHECK;
               end else begin
                  settle_cnt_q <= settle_cnt_q - LP_SETTLE_ONE;
               end
            end
            S_CHECK: begin
               check_strobe_q <= 1'b0;
               if (row_fail_s) begin
                  pass_q     <= 1'b0;
                  fail_cnt_q <= fail_cnt_d;
                  // pass_q still high means this is the first failing row of the run
                  if (pass_q) begin
                     fail_row_q  <= row_idx_q;
                     fail_mask_q <= ~bus.i_detect_vld;
                  end
               end
               if (last_row_s || (row_fail_s && stop_q)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  row_idx_q  <= row_idx_d;
                  row_addr_q <= row_idx_d;
                  row_rd_q   <= 1'b1;
                  state_q    <= S_READ;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               row_rd_q       <= 1'b0;
               check_strobe_q <= 1'b0;
               done_q         <= 1'b0;
               busy_q         <= 1'b0;
               state_q        <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_row_addr     = row_addr_q;
   assign bus.o_row_rd       = row_rd_q;
   assign bus.o_stim_data    = stim_data_q;
   assign bus.o_stim_oe      = stim_oe_q;
   assign bus.o_channel_vld  = channel_vld_q;
   assign bus.o_check_strobe = check_strobe_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_done         = done_q;
   assign bus.o_pass         = pass_q;
   assign bus.o_fail_row     = fail_row_q;
   assign bus.o_fail_mask    = fail_mask_q;
   assign bus.o_fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_truth_table_stimulus_seq.sv
// Bench for truth_table_stimulus_seq: a schedule-based model predicts every output each
// cycle from the run parameters and row tables; directed runs add literal expectations.
module tb_truth_table_stimulus_seq;
   localparam int CH   = 16;
   localparam int AW   = 6;
   localparam int SW   = 16;
   localparam int CW   = 8;
   localparam int ROWS = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   truth_table_stimulus_seq_if #(.P_CH_NUM(CH), .P_ROW_AW(AW), .P_SETTLE_W(SW), .P_CNT_W(CW)) bus ();

   truth_table_stimulus_seq #(.P_CH_NUM(CH), .P_ROW_AW(AW), .P_SETTLE_W(SW), .P_CNT_W(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [CH-1:0] stim_mem [ROWS];
   logic [CH-1:0] chk_mem  [ROWS];
   logic [CH-1:0] det_mem  [ROWS];

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // model state
   bit            m_live = 1'b0;
   bit            m_active = 1'b0;
   bit            m_rst_pend = 1'b0;
   int            t0 = 0;
   int            m_n = 0;
   int            m_reff = 0;
   int            m_done_k = 0;
   logic [CH-1:0] e_stim, e_oe, e_vld, e_mask;
   logic [AW-1:0] e_row;
   logic [CW-1:0] e_cnt;
   logic          e_pass;
   int            strobe_q[$];
   int            rd_q[$];
   int            last_done_k = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int reff_of(input int cnt, input bit stop);
      int c;
      c = (cnt > ROWS) ? ROWS : cnt;
      if (stop) begin
         for (int r = 0; r < c; r++) begin
            if (det_mem[r] != '1) return r + 1;
         end
      end
      return c;
   endfunction

   task automatic model_reset();
      e_stim = '0; e_oe = '0; e_vld = '0; e_mask = '0; e_row = '0; e_cnt = '0; e_pass = 1'b1;
   endtask

   task automatic model_apply(input int row);
      if (det_mem[row] != '1) begin
         if (e_pass) begin
            e_row  = AW'(row);
            e_mask = ~det_mem[row];
         end
         e_pass = 1'b0;
         e_cnt  = (e_cnt == '1) ? e_cnt : e_cnt + 1'b1;
      end
   endtask

   // row RAM: one-cycle read latency, undefined data when not read
   always @(posedge clk) begin
      if (bus.o_row_rd === 1'b1) begin
         bus.i_row_stim <= stim_mem[bus.o_row_addr];
         bus.i_row_chk  <= chk_mem[bus.o_row_addr];
      end else begin
         bus.i_row_stim <= CH'($urandom);
         bus.i_row_chk  <= CH'($urandom);
      end
   end

   // detectors: row result in the predicted check cycle, noise elsewhere
   always @(posedge clk) begin
      int k, p;
      #1;
      bus.i_detect_vld = CH'($urandom);
      if (m_active) begin
         k = cyc - t0;
         p = m_n + 3;
         if (k >= p && (k % p) == 0 && (k / p - 1) < m_reff) bus.i_detect_vld = det_mem[k / p - 1];
      end
   end

   // compare process: predict this cycle from the run schedule, then compare
   always @(negedge clk) begin
      int k, p, r, ph, x_addr;
      bit x_busy, x_done, x_rd, x_strobe;
      if (m_rst_pend) begin
         model_reset();
         m_active = 1'b0;
         m_live   = 1'b1;
      end
      x_busy = 1'b0; x_done = 1'b0; x_rd = 1'b0; x_strobe = 1'b0; x_addr = 0;
      if (m_active) begin
         k = cyc - t0;
         p = m_n + 3;
         if (k > m_done_k) begin
            m_active = 1'b0;
         end else if (k >= 1) begin
            x_busy = 1'b1;
            x_done = (k == m_done_k);
            if (k == 1) begin
               e_pass = 1'b1; e_row = '0; e_mask = '0; e_cnt = '0;
            end
            r  = (k - 1) / p;
            ph = (k - 1) % p;
            if (ph == 0 && r < m_reff) begin x_rd = 1'b1; x_addr = r; end
            if (ph == 2 && r < m_reff) begin
               e_stim = stim_mem[r]; e_oe = ~chk_mem[r]; e_vld = chk_mem[r];
            end
            if (ph == p - 1 && r < m_reff) x_strobe = 1'b1;
            if (ph == 0 && r >= 1 && (r - 1) < m_reff) model_apply(r - 1);
         end
      end
      if (m_live) begin
         chk("busy",   64'(bus.o_busy),         64'(x_busy));
         chk("done",   64'(bus.o_done),         64'(x_done));
         chk("row_rd", 64'(bus.o_row_rd),       64'(x_rd));
         chk("strobe", 64'(bus.o_check_strobe), 64'(x_strobe));
         if (x_rd) chk("row_addr", 64'(bus.o_row_addr), 64'(x_addr));
         chk("stim_data",   64'(bus.o_stim_data),   64'(e_stim));
         chk("stim_oe",     64'(bus.o_stim_oe),     64'(e_oe));
         chk("channel_vld", 64'(bus.o_channel_vld), 64'(e_vld));
         chk("pass",        64'(bus.o_pass),        64'(e_pass));
         chk("fail_row",    64'(bus.o_fail_row),    64'(e_row));
         chk("fail_mask",   64'(bus.o_fail_mask),   64'(e_mask));
         chk("fail_cnt",    64'(bus.o_fail_cnt),    64'(e_cnt));
         if (bus.o_check_strobe === 1'b1) strobe_q.push_back(cyc - t0);
         if (bus.o_row_rd === 1'b1) rd_q.push_back(int'(bus.o_row_addr));
         if (bus.o_done === 1'b1) last_done_k = cyc - t0;
         if (!x_busy && bus.i_start === 1'b1 && rst !== 1'b1) begin
            t0       = cyc;
            m_active = 1'b1;
            m_n      = int'(bus.i_settle_cycles);
            m_reff   = reff_of(int'(bus.i_row_count), bus.i_stop_on_fail);
            m_done_k = 1 + m_reff * (m_n + 3);
         end
      end
      m_rst_pend = (rst === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int pct);
      logic [CH-1:0] d;
      for (int r = 0; r < ROWS; r++) begin
         stim_mem[r] = CH'($urandom);
         chk_mem[r]  = CH'($urandom);
         d = '1;
         if ($urandom_range(0, 99) < pct) begin
            d = CH'($urandom);
            d[$urandom_range(0, CH - 1)] = 1'b0;
         end
         det_mem[r] = d;
      end
   endtask

   task automatic start_run(input int cnt, input int n, input bit stop);
      strobe_q.delete();
      rd_q.delete();
      last_done_k        = -1;
      bus.i_start         = 1'b1;
      bus.i_row_count     = (AW + 1)'(cnt);
      bus.i_settle_cycles = SW'(n);
      bus.i_stop_on_fail  = stop;
      tick();
      bus.i_start         = 1'b0;
      bus.i_row_count     = (AW + 1)'($urandom);
      bus.i_settle_cycles = SW'($urandom);
      bus.i_stop_on_fail  = 1'($urandom);
   endtask

   task automatic wait_done(input bit poke);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (bus.o_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         bus.i_start         = poke && ($urandom_range(0, 7) == 0);
         bus.i_row_count     = (AW + 1)'($urandom);
         bus.i_settle_cycles = SW'($urandom_range(0, 5));
         bus.i_stop_on_fail  = 1'($urandom);
      end
      chk("done_seen", 64'(seen), 64'h1);
      tick();
      bus.i_start = 1'b0;
   endtask

   initial begin
      bus.i_start = 1'b0; bus.i_row_count = '0; bus.i_settle_cycles = '0; bus.i_stop_on_fail = 1'b0;
      bus.i_detect_vld = '1;
      fill(0);
      model_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pass", 64'(bus.o_pass), 64'h1);
      chk("rst_oe",   64'(bus.o_stim_oe), 64'h0);
      chk("rst_busy", 64'(bus.o_busy), 64'h0);
      tick();

      // four passing rows, settle 2
      fill(0);
      start_run(4, 2, 1'b0);
      wait_done(1'b0);
      chk("t1_strobes", 64'(strobe_q.size()), 64'd4);
      if (strobe_q.size() == 4) begin
         chk("t1_strobe0", 64'(strobe_q[0]), 64'd5);
         chk("t1_strobe1", 64'(strobe_q[1]), 64'd10);
         chk("t1_strobe2", 64'(strobe_q[2]), 64'd15);
         chk("t1_strobe3", 64'(strobe_q[3]), 64'd20);
      end
      chk("t1_done_k", 64'(last_done_k), 64'd21);
      chk("t1_pass",   64'(bus.o_pass), 64'h1);
      chk("t1_cnt",    64'(bus.o_fail_cnt), 64'h0);

      // row 2 fails, run continues
      det_mem[2] = 16'hFFF7;
      start_run(4, 2, 1'b0);
      wait_done(1'b0);
      chk("t2_model_done_k", 64'(m_done_k), 64'd21);
      chk("t2_done_k",    64'(last_done_k), 64'd21);
      chk("t2_fail_row",  64'(bus.o_fail_row), 64'd2);
      chk("t2_fail_mask", 64'(bus.o_fail_mask), 64'h0008);
      chk("t2_fail_cnt",  64'(bus.o_fail_cnt), 64'd1);
      chk("t2_pass",      64'(bus.o_pass), 64'h0);

      // same with stop-on-fail
      start_run(4, 2, 1'b1);
      wait_done(1'b0);
      chk("t3_model_reff", 64'(m_reff), 64'd3);
      chk("t3_done_k",   64'(last_done_k), 64'd16);
      chk("t3_reads",    64'(rd_q.size()), 64'd3);
      if (rd_q.size() > 0) chk("t3_last_read", 64'(rd_q[rd_q.size() - 1]), 64'd2);
      chk("t3_fail_row", 64'(bus.o_fail_row), 64'd2);

      // zero rows
      start_run(0, 3, 1'b0);
      wait_done(1'b0);
      chk("t4_done_k", 64'(last_done_k), 64'd1);
      chk("t4_reads",  64'(rd_q.size()), 64'd0);
      chk("t4_pass",   64'(bus.o_pass), 64'h1);

      // settle 0, fixed row 0, start during busy ignored
      fill(0);
      stim_mem[0] = 16'hA5A5;
      chk_mem[0]  = 16'h00FF;
      start_run(1, 0, 1'b0);
      bus.i_start = 1'b1; bus.i_row_count = 7'd5; bus.i_settle_cycles = 16'd7;
      tick();
      bus.i_start = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_stim",   64'(bus.o_stim_data), 64'hA5A5);
      chk("t5_oe",     64'(bus.o_stim_oe), 64'hFF00);
      chk("t5_vld",    64'(bus.o_channel_vld), 64'h00FF);
      chk("t5_strobe", 64'(bus.o_check_strobe), 64'h1);
      wait_done(1'b0);
      chk("t5_done_k", 64'(last_done_k), 64'd4);

      // reset during settle
      det_mem[1] = 16'h7FFF;
      start_run(4, 5, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_busy",   64'(bus.o_busy), 64'h0);
      chk("t6_done",   64'(bus.o_done), 64'h0);
      chk("t6_oe",     64'(bus.o_stim_oe), 64'h0);
      chk("t6_stim",   64'(bus.o_stim_data), 64'h0);
      chk("t6_vld",    64'(bus.o_channel_vld), 64'h0);
      chk("t6_strobe", 64'(bus.o_check_strobe), 64'h0);
      chk("t6_pass",   64'(bus.o_pass), 64'h1);
      repeat (3) tick();
      start_run(2, 1, 1'b0);
      wait_done(1'b0);
      chk("t6_first_read", (rd_q.size() > 0) ? 64'(rd_q[0]) : 64'hDEAD, 64'd0);
      chk("t6_done_k",     64'(last_done_k), 64'd9);
      chk("t6_fail_row",   64'(bus.o_fail_row), 64'd1);

      // row count above table depth is clamped
      fill(0);
      start_run(100, 0, 1'b0);
      wait_done(1'b0);
      chk("clamp_done_k", 64'(last_done_k), 64'd193);
      chk("clamp_reads",  64'(rd_q.size()), 64'd64);
      if (rd_q.size() == 64) chk("clamp_last_read", 64'(rd_q[63]), 64'd63);

      // randomized runs with busy-start pokes and occasional mid-run reset
      for (int run = 0; run < 25; run++) begin
         int cnt, n;
         fill(25);
         if ($urandom_range(0, 9) == 0) begin
            cnt = $urandom_range(0, 127);
            n   = $urandom_range(0, 3);
         end else begin
            cnt = $urandom_range(0, 12);
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 3);
         end
         start_run(cnt, n, 1'($urandom));
         if ($urandom_range(0, 5) == 0) begin
            repeat ($urandom_range(1, 10)) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
         end else begin
            wait_done(1'b1);
         end
      end

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
